// File: rtl/pe_row_feeder.sv
// Row-stationary PE sequencer: loads a filter row and an image row, then replays them as 1-D sliding windows.
// Result leaves 2 cycles after a window's last tap; load streams stall the job indefinitely, result port has no backpressure.
module pe_row_feeder #(
    parameter int FILT_LEN  = 3,
    parameter int IMG_LEN   = 8,
    parameter int DW        = 16,
    parameter int PW        = 32,
    parameter int ISSUE_GAP = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          keep_wgt,
    output logic          busy,
    output logic          done,
    input  logic          wgt_valid,
    output logic          wgt_ready,
    input  logic [DW-1:0] wgt_data,
    input  logic          img_valid,
    output logic          img_ready,
    input  logic [DW-1:0] img_data,
    output logic [DW-1:0] image_val,
    output logic          image_en,
    output logic [DW-1:0] weight_val,
    output logic          weight_en,
    output logic [PW-1:0] psum_in,
    input  logic [PW-1:0] psum_fb,
    output logic          out_valid,
    output logic [5:0]    out_idx,
    output logic [PW-1:0] out_data
);

    localparam int WIN_LEN = 1 + FILT_LEN * ISSUE_GAP;
    localparam int CAP_OFS = 2 + (FILT_LEN - 1) * ISSUE_GAP;
    localparam int WCW     = $clog2(FILT_LEN + 1);
    localparam int ICW     = $clog2(IMG_LEN + 1);
    localparam int WAW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int IAW     = (IMG_LEN > 1) ? $clog2(IMG_LEN) : 1;
    localparam int CW      = $clog2(WIN_LEN + 2);
    localparam int GW      = $clog2(ISSUE_GAP);

    localparam logic [WCW-1:0] S_CNT   = WCW'(FILT_LEN);
    localparam logic [ICW-1:0] W_CNT   = ICW'(IMG_LEN);
    localparam logic [CW-1:0]  WIN_END = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0]  CAP_CYC = CW'(CAP_OFS);
    localparam logic [GW-1:0]  GAP_RLD = GW'(ISSUE_GAP - 1);
    localparam logic [5:0]     LAST_E  = 6'(IMG_LEN - FILT_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic            keep_q;
    logic [WCW-1:0]  wcnt_q;
    logic [ICW-1:0]  icnt_q;
    logic [5:0]      e_q;
    logic [CW-1:0]   cyc_q;
    logic [WCW-1:0]  tap_q;
    logic [GW-1:0]   gap_q;
    logic            out_valid_q;
    logic [5:0]      out_idx_q;
    logic [PW-1:0]   out_data_q;

    logic [DW-1:0]   wgt_mem [FILT_LEN];
    logic [DW-1:0]   img_mem [IMG_LEN];

    logic            wgt_full, img_full, tap_fire, cap, last_win;
    logic [IAW-1:0]  img_idx;

    assign wgt_full = keep_q || (wcnt_q == S_CNT);
    assign img_full = (icnt_q == W_CNT);
    assign last_win = (e_q == LAST_E);
    // Taps only while the window still has some left; gap_q paces them ISSUE_GAP apart.
    assign tap_fire = (state_q == RUN) && (cyc_q != '0) && (gap_q == '0) && (tap_q != S_CNT);
    assign cap      = (state_q == RUN) && (cyc_q == CAP_CYC);
    assign img_idx  = IAW'(e_q) + IAW'(tap_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        wgt_ready  = 1'b0;
        img_ready  = 1'b0;
        image_en   = 1'b0;
        weight_en  = 1'b0;
        image_val  = '0;
        weight_val = '0;
        psum_in    = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                wgt_ready = !wgt_full;
                img_ready = !img_full;
                if (wgt_full && img_full) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cyc_q != '0) psum_in = psum_fb;
                if (tap_fire) begin
                    image_en   = 1'b1;
                    weight_en  = 1'b1;
                    image_val  = img_mem[img_idx];
                    weight_val = wgt_mem[WAW'(tap_q)];
                end
                if (out_valid_q && (out_idx_q == LAST_E)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scratchpads carry no reset; their contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && wgt_valid && wgt_ready) wgt_mem[WAW'(wcnt_q)] <= wgt_data;
        if (state_q == LOAD && img_valid && img_ready) img_mem[IAW'(icnt_q)] <= img_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keep_q      <= 1'b0;
            wcnt_q      <= '0;
            icnt_q      <= '0;
            e_q         <= '0;
            cyc_q       <= '0;
            tap_q       <= '0;
            gap_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= cap;
            if (cap) begin
                out_data_q <= psum_fb;
                out_idx_q  <= e_q;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        keep_q <= keep_wgt;
                        wcnt_q <= '0;
                        icnt_q <= '0;
                    end
                end
                LOAD: begin
                    if (wgt_valid && wgt_ready) wcnt_q <= wcnt_q + WCW'(1);
                    if (img_valid && img_ready) icnt_q <= icnt_q + ICW'(1);
                    e_q   <= '0;
                    cyc_q <= '0;
                    tap_q <= '0;
                    gap_q <= '0;
                end
                RUN: begin
                    if (tap_fire) begin
                        tap_q <= tap_q + WCW'(1);
                        gap_q <= GAP_RLD;
                    end else if (gap_q != '0) begin
                        gap_q <= gap_q - GW'(1);
                    end
                    // The last window runs past WIN_END until its result has been presented.
                    if (cyc_q == WIN_END && !last_win) begin
                        cyc_q <= '0;
                        e_q   <= e_q + 6'd1;
                        tap_q <= '0;
                        gap_q <= '0;
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;

endmodule
